// File: rtl/sync_filter_edge.sv
// Multi-channel level synchronizer: flop chain, glitch filter, optional registered edge pulses.
// Define SYNC_EDGE_DET_EN to build RISE/FALL/CHANGE; otherwise those ports are tied to 0.
module sync_filter_edge #(
  parameter int unsigned          BUS_WIDTH     = 1,
  parameter int unsigned          NUM_STAGES    = 2,
  parameter int unsigned          FILTER_CYCLES = 3,
  parameter logic [BUS_WIDTH-1:0] RST_VAL       = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] ASYNC,
  output logic [BUS_WIDTH-1:0] SYNC,
  output logic [BUS_WIDTH-1:0] RISE,
  output logic [BUS_WIDTH-1:0] FALL,
  output logic                 CHANGE
);

  localparam int unsigned      CNT_W   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic [BUS_WIDTH-1:0] stage_q [NUM_STAGES];
  logic [BUS_WIDTH-1:0] raw;
  logic [BUS_WIDTH-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]     cnt_q [BUS_WIDTH];
  logic [CNT_W-1:0]     cnt_d [BUS_WIDTH];

  assign raw = stage_q[NUM_STAGES-1];

  // A differing raw level must persist FILTER_CYCLES cycles; any return to SYNC drops the credit.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a latch behind.
    sync_d = sync_q;
    for (int i = 0; i < int'(BUS_WIDTH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (raw[i] == sync_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        sync_d[i] = raw[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < int'(NUM_STAGES); k++) stage_q[k] <= RST_VAL;
      for (int i = 0; i < int'(BUS_WIDTH); i++) cnt_q[i] <= '0;
      sync_q <= RST_VAL;
    end else begin
      // NOTE: non-blocking assignments let the chain shift one stage per edge regardless of order.
      stage_q[0] <= ASYNC;
      for (int k = 1; k < int'(NUM_STAGES); k++) stage_q[k] <= stage_q[k-1];
      for (int i = 0; i < int'(BUS_WIDTH); i++) cnt_q[i] <= cnt_d[i];
      sync_q <= sync_d;
    end
  end

  assign SYNC = sync_q;

`ifdef SYNC_EDGE_DET_EN
  logic [BUS_WIDTH-1:0] rise_q, fall_q;
  logic                 change_q;

  // Pulses are registered from the same next-state that updates SYNC, so they align with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      rise_q   <= sync_d & ~sync_q;
      fall_q   <= ~sync_d & sync_q;
      change_q <= |(sync_d ^ sync_q);
    end
  end

  assign RISE   = rise_q;
  assign FALL   = fall_q;
  assign CHANGE = change_q;
`else
  assign RISE   = '0;
  assign FALL   = '0;
  assign CHANGE = 1'b0;
`endif

endmodule
